// File: rtl/cve2_sleep_ctrl.sv
// Core clock-gate enable and sleep controller.
// Gates the core clock after a programmable idle run and wakes it on any
// unmasked wake request, on core busy or when sleeping is disallowed.
//
// Ports:
//   clk_i, rst_i     free-running clock, async active-high reset
//   test_en_i        DFT override, forces clk_en_o high
//   core_busy_i      core reports activity
//   sleep_allow_i    1 = gating permitted
//   wake_req_i       level wake requests, one per source
//   wake_mask_i      1 = source may wake / hold the core awake
//   clk_en_o         enable for the core clock gate
//   core_sleep_o     inverse of clk_en_o
//   wake_src_o       masked sources seen at the last SLEEP exit
//   wake_evt_o       one-cycle pulse after each SLEEP exit
//   sleep_cnt_o      cycles spent in the last/current SLEEP, saturating
module cve2_sleep_ctrl #(
    parameter int unsigned NumWakeSrc = 4,
    parameter int unsigned IdleDelay  = 4,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic                  core_busy_i,
    input  logic                  sleep_allow_i,
    input  logic [NumWakeSrc-1:0] wake_req_i,
    input  logic [NumWakeSrc-1:0] wake_mask_i,
    output logic                  clk_en_o,
    output logic                  core_sleep_o,
    output logic [NumWakeSrc-1:0] wake_src_o,
    output logic                  wake_evt_o,
    output logic [CntWidth-1:0]   sleep_cnt_o
);

    if (NumWakeSrc < 1 || NumWakeSrc > 32) begin : g_bad_nsrc
        $error("NumWakeSrc out of range 1..32");
    end
    if (IdleDelay > 255) begin : g_bad_dly
        $error("IdleDelay out of range 0..255");
    end
    if (CntWidth < 4 || CntWidth > 32) begin : g_bad_cw
        $error("CntWidth out of range 4..32");
    end

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        SLEEP     = 2'd2
    } state_e;

    localparam bit          NoDelay  = (IdleDelay == 0);
    localparam int unsigned TermInt  = NoDelay ? 0 : IdleDelay - 1;
    localparam logic [7:0]  IdleTerm = TermInt[7:0];
    localparam logic [CntWidth-1:0] CntMax = '1;

    state_e                state_q, state_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic [CntWidth-1:0]   sleep_cnt_q, sleep_cnt_d;
    logic [NumWakeSrc-1:0] wake_src_q, wake_src_d;
    logic                  wake_evt_q, wake_evt_d;

    logic [NumWakeSrc-1:0] wake_masked;
    logic                  wake_any;
    logic                  idle;

    assign wake_masked = wake_req_i & wake_mask_i;
    assign wake_any    = |wake_masked;
    assign idle        = ~core_busy_i & sleep_allow_i & ~wake_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            idle_cnt_q  <= '0;
            sleep_cnt_q <= '0;
            wake_src_q  <= '0;
            wake_evt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            sleep_cnt_q <= sleep_cnt_d;
            wake_src_q  <= wake_src_d;
            wake_evt_q  <= wake_evt_d;
        end
    end

    // Next state. Any non-idle cycle (wake included) keeps or returns
    // the core to RUN, so a wake always beats a terminal idle count.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            RUN: begin
                if (idle) begin
                    if (NoDelay) begin
                        state_d = SLEEP;
                    end else begin
                        state_d    = IDLE_WAIT;
                        idle_cnt_d = '0;
                    end
                end
            end
            IDLE_WAIT: begin
                if (!idle) begin
                    state_d    = RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IdleTerm) begin
                    state_d = SLEEP;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            SLEEP: begin
                if (!idle) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Sleep statistics: the counter covers every cycle spent in SLEEP,
    // including the exit cycle, and is held until the next entry.
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        wake_src_d  = wake_src_q;
        wake_evt_d  = 1'b0;
        if (state_q == SLEEP) begin
            if (sleep_cnt_q != CntMax) begin
                sleep_cnt_d = sleep_cnt_q + 1'b1;
            end
            if (state_d != SLEEP) begin
                wake_evt_d = 1'b1;
                wake_src_d = wake_masked;
            end
        end else if (state_d == SLEEP) begin
            sleep_cnt_d = '0;
        end
    end

    // Wake path is purely combinational so the clock returns in the
    // same cycle the request arrives.
    always_comb begin
        clk_en_o     = test_en_i | (state_q != SLEEP) | wake_any;
        core_sleep_o = ~clk_en_o;
        wake_src_o   = wake_src_q;
        wake_evt_o   = wake_evt_q;
        sleep_cnt_o  = sleep_cnt_q;
    end

    a_clk_en_known: assert property (
        @(posedge clk_i) disable iff (rst_i) !$isunknown(clk_en_o));

    a_evt_single: assert property (
        @(posedge clk_i) disable iff (rst_i) wake_evt_o |=> !wake_evt_o);

    a_wake_ungates: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(state_q == SLEEP && wake_any && !clk_en_o));

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Bench for cve2_sleep_ctrl: three instances (delay 4 / 4-bit counter /
// delay 0) driven by shared stimulus and checked against an idle-run model.
module tb_cve2_sleep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       test_en = 1'b0;
    logic       busy    = 1'b0;
    logic       allow   = 1'b1;
    logic [3:0] req     = 4'b0000;
    logic [3:0] mask    = 4'b1111;

    logic       en_o[3];
    logic       sl_o[3];
    logic       ev_o[3];
    logic [3:0] sr_o[3];
    logic [15:0] c0;
    logic [3:0]  c1;
    logic [15:0] c2;

    int n_cmp = 0;
    int n_bad = 0;

    cve2_sleep_ctrl #(.NumWakeSrc(4), .IdleDelay(4), .CntWidth(16)) u0 (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .core_busy_i(busy), .sleep_allow_i(allow),
        .wake_req_i(req), .wake_mask_i(mask),
        .clk_en_o(en_o[0]), .core_sleep_o(sl_o[0]),
        .wake_src_o(sr_o[0]), .wake_evt_o(ev_o[0]), .sleep_cnt_o(c0));

    cve2_sleep_ctrl #(.NumWakeSrc(4), .IdleDelay(4), .CntWidth(4)) u1 (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .core_busy_i(busy), .sleep_allow_i(allow),
        .wake_req_i(req), .wake_mask_i(mask),
        .clk_en_o(en_o[1]), .core_sleep_o(sl_o[1]),
        .wake_src_o(sr_o[1]), .wake_evt_o(ev_o[1]), .sleep_cnt_o(c1));

    cve2_sleep_ctrl #(.NumWakeSrc(4), .IdleDelay(0), .CntWidth(16)) u2 (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .core_busy_i(busy), .sleep_allow_i(allow),
        .wake_req_i(req), .wake_mask_i(mask),
        .clk_en_o(en_o[2]), .core_sleep_o(sl_o[2]),
        .wake_src_o(sr_o[2]), .wake_evt_o(ev_o[2]), .sleep_cnt_o(c2));

    function automatic logic [31:0] cnt_of(input int i);
        if (i == 0) return {16'd0, c0};
        if (i == 1) return {28'd0, c1};
        return {16'd0, c2};
    endfunction

    function automatic int dly(input int i);
        return (i == 2) ? 0 : 4;
    endfunction

    function automatic int cmax(input int i);
        return (i == 1) ? 15 : 65535;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    // Model: the core sleeps once it has seen IdleDelay+1 consecutive
    // idle cycles; it stays asleep exactly as long as it stays idle.
    bit         m_sleep[3] = '{default: 1'b0};
    int         m_run[3]   = '{default: 0};
    int         m_cnt[3]   = '{default: 0};
    logic [3:0] m_src[3]   = '{default: 4'b0000};
    bit         m_evt[3]   = '{default: 1'b0};

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] m;
        bit         idle;
        bit         s;
        int         r;
        int         c;
        m    = req & mask;
        idle = !busy && allow && (m == 4'b0000);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_sleep[i] <= 1'b0;
                m_run[i]   <= 0;
                m_cnt[i]   <= 0;
                m_src[i]   <= 4'b0000;
                m_evt[i]   <= 1'b0;
            end else begin
                s = m_sleep[i];
                r = m_run[i];
                c = m_cnt[i];
                if (s) begin
                    if (c < cmax(i)) c = c + 1;
                    s = idle;
                    r = 0;
                end else if (idle) begin
                    r = r + 1;
                    if (r > dly(i)) begin
                        s = 1'b1;
                        c = 0;
                        r = 0;
                    end
                end else begin
                    r = 0;
                end
                m_evt[i] <= m_sleep[i] && !idle;
                if (m_sleep[i] && !idle) m_src[i] <= m;
                m_sleep[i] <= s;
                m_run[i]   <= r;
                m_cnt[i]   <= c;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_en;
        for (int i = 0; i < 3; i++) begin
            exp_en = test_en || !m_sleep[i] || ((req & mask) != 4'b0000);
            chk($sformatf("clk_en[%0d]", i), {31'd0, en_o[i]},
                {31'd0, exp_en});
            chk($sformatf("core_sleep[%0d]", i), {31'd0, sl_o[i]},
                {31'd0, !exp_en});
            chk($sformatf("wake_src[%0d]", i), {28'd0, sr_o[i]},
                {28'd0, m_src[i]});
            chk($sformatf("wake_evt[%0d]", i), {31'd0, ev_o[i]},
                {31'd0, m_evt[i]});
            chk($sformatf("sleep_cnt[%0d]", i), cnt_of(i), m_cnt[i]);
        end
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("rst_clk_en", {31'd0, en_o[i]}, 32'd1);
                chk("rst_sleep", {31'd0, sl_o[i]}, 32'd0);
                chk("rst_cnt", cnt_of(i), 32'd0);
                chk("rst_src", {28'd0, sr_o[i]}, 32'd0);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int c = 0; c < 46; c++) begin
            mask = (c >= 5) ? 4'b1101 : 4'b1111;
            if (c >= 8 && c <= 10) req = 4'b0010;
            else if (c == 11 || (c >= 42 && c <= 44)) req = 4'b0100;
            else req = 4'b0000;
            busy    = (c == 14);
            test_en = (c == 21 || c == 22);
            @(negedge clk);
            if (c <= 4) chk("gate_wait_d4", {31'd0, en_o[0]}, 32'd1);
            if (c == 5) begin
                chk("gate_d4", {31'd0, en_o[0]}, 32'd0);
                chk("sleep_d4", {31'd0, sl_o[0]}, 32'd1);
                chk("cnt_entry", cnt_of(0), 32'd0);
            end
            if (c == 0) chk("gate_wait_d0", {31'd0, en_o[2]}, 32'd1);
            if (c == 1) chk("gate_d0", {31'd0, en_o[2]}, 32'd0);
            if (c == 8) chk("masked_req", {31'd0, en_o[0]}, 32'd0);
            if (c == 11) chk("comb_wake", {31'd0, en_o[0]}, 32'd1);
            if (c == 12) begin
                chk("wake_src", {28'd0, sr_o[0]}, 32'h4);
                chk("wake_evt", {31'd0, ev_o[0]}, 32'd1);
                chk("cnt7", cnt_of(0), 32'd7);
                chk("cnt7_cw4", cnt_of(1), 32'd7);
                chk("cnt11_d0", cnt_of(2), 32'd11);
            end
            if (c == 13) chk("wake_evt_off", {31'd0, ev_o[0]}, 32'd0);
            if (c == 19) chk("busy_restart", {31'd0, en_o[0]}, 32'd1);
            if (c == 20) chk("busy_regate", {31'd0, en_o[0]}, 32'd0);
            if (c == 21) begin
                chk("test_en_clk", {31'd0, en_o[0]}, 32'd1);
                chk("test_en_slp", {31'd0, sl_o[0]}, 32'd0);
            end
            if (c == 22) begin
                chk("test_en_d0", {31'd0, en_o[2]}, 32'd1);
                chk("test_en_cnt", cnt_of(2), 32'd6);
            end
            if (c == 42) begin
                chk("cnt22", cnt_of(0), 32'd22);
                chk("cnt_sat", cnt_of(1), 32'd15);
            end
            if (c == 43) begin
                chk("cnt23", cnt_of(0), 32'd23);
                chk("sat_held", cnt_of(1), 32'd15);
                chk("evt_cw4", {31'd0, ev_o[1]}, 32'd1);
            end
            if (c >= 43 && c <= 45)
                chk("idle_wake_run", {31'd0, en_o[2]}, 32'd1);
            if (c == 45) chk("sat_held2", cnt_of(1), 32'd15);
            @(posedge clk);
            #2;
        end

        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            busy    = ($urandom_range(0, 9) == 0);
            allow   = ($urandom_range(0, 15) != 0);
            test_en = ($urandom_range(0, 31) == 0);
            for (int b = 0; b < 4; b++)
                req[b] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) mask = 4'($urandom());
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
